// File: rtl/fs_accel_wfetch_if.sv
// fs_accel_wfetch_if
//   Bundles the two streams of the weight fetch stage:
//     - word stream: packed 32-bit weight words, from memory/DMA into the block
//     - row stream : 3-byte kernel rows, from the block to the weight row register
//
//   Handshake rule, shared by both streams: a transfer happens on a rising
//   clock edge where valid and ready are both high. A source never withdraws
//   valid or changes its payload until that transfer has happened. A sink may
//   raise or lower ready on any cycle.
//
//   Modports:
//     slave  : the fetch block. It sinks words and sources rows.
//     master : the environment. It sources words and sinks rows.
//
//   Signals:
//     in_data    [31:0] packed weight word; byte 0 = bits[7:0] is the first weight
//     in_valid          in_data is valid
//     in_ready          block accepts in_data this cycle
//     wrow_0..2  [7:0]  row bytes, wrow_0 = lowest address
//     wrow_valid        row outputs hold a valid row
//     wrow_ready        downstream takes the row this cycle
//     wreg_enb          wrow_valid & wrow_ready; the row register's capture enable
//     wrow_last         current row is the last row of a kernel
interface fs_accel_wfetch_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  wrow_0;
  logic [7:0]  wrow_1;
  logic [7:0]  wrow_2;
  logic        wrow_valid;
  logic        wrow_ready;
  logic        wreg_enb;
  logic        wrow_last;

  modport slave (
    input  in_data, in_valid, wrow_ready,
    output in_ready, wrow_0, wrow_1, wrow_2, wrow_valid, wreg_enb, wrow_last
  );

  modport master (
    output in_data, in_valid, wrow_ready,
    input  in_ready, wrow_0, wrow_1, wrow_2, wrow_valid, wreg_enb, wrow_last
  );
endinterface

// File: rtl/fs_accel_wfetch.sv
// fs_accel_wfetch
//   Weight fetch/unpack stage. It sits directly upstream of the 3-byte weight
//   row register. Packed 32-bit words are split into bytes in an 8-entry byte
//   buffer. The bytes are regrouped into 3-byte kernel rows, and each row is
//   presented with the enable pulse the row register needs to capture it.
//   Every kernel starts on a word boundary. Pad bytes at the end of a kernel's
//   last word are dropped.
//
//   Parameters:
//     KROWS      kernel rows per kernel (1..8)
//
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous, active-high reset; aborts any fetch in progress
//     start      one-cycle pulse; honoured only in IDLE
//     n_kern     number of kernels to fetch; sampled on start
//     bus        word-in / row-out streams (see fs_accel_wfetch_if)
//     busy       high in RUN and DRAIN
//     done       one-cycle pulse when the fetch completes
//     state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
module fs_accel_wfetch #(
  parameter int KROWS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             n_kern,
  fs_accel_wfetch_if.slave        bus,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              state_dbg
);

  // Words per kernel. Each kernel begins word-aligned.
  localparam int WPK = (3 * KROWS + 3) / 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_n;

  logic [7:0]  bbuf_q [8];
  logic [7:0]  bbuf_n [8];
  logic [3:0]  bcnt_q, bcnt_n;
  logic [3:0]  word_cnt_q;
  logic [2:0]  row_cnt_q;
  logic [15:0] kern_cnt_q;
  logic [15:0] n_kern_q;

  logic [7:0]  wrow0_q, wrow1_q, wrow2_q;
  logic        wrow_valid_q;
  logic        wrow_last_q;
  logic        done_q;

  logic        in_ready_c;
  logic        word_acc;
  logic        row_take;
  logic        row_load;
  logic        kern_end;
  logic        last_kern;
  logic        start_go;
  logic        start_zero;
  logic [3:0]  base;

  // Datapath qualifiers. All of them use registered state, so in_ready does
  // not depend on in_valid in the same cycle.
  assign word_acc   = bus.in_valid && in_ready_c;
  assign row_take   = wrow_valid_q && bus.wrow_ready;
  assign row_load   = (state_q == S_RUN) && (bcnt_q >= 4'd3) &&
                      (!wrow_valid_q || bus.wrow_ready);
  assign kern_end   = row_load && (row_cnt_q == 3'(KROWS - 1));
  assign last_kern  = ((kern_cnt_q + 16'd1) == n_kern_q);
  assign start_go   = (state_q == S_IDLE) && start && (n_kern != 16'd0);
  assign start_zero = (state_q == S_IDLE) && start && (n_kern == 16'd0);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  // FSM: next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_n = S_RUN;
      S_RUN:   if (kern_end && last_kern) state_n = S_DRAIN;
      S_DRAIN: if (row_take) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready_c = (state_q == S_RUN) && (word_cnt_q < 4'(WPK)) && (bcnt_q <= 4'd4);
    busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    state_dbg  = state_q;
  end

  // Byte buffer next value. A row load shifts the buffer down by 3 first, so
  // a word accepted in the same cycle lands at bcnt-3. Accepts only happen
  // with bcnt <= 4, so base+3 never passes index 7. At kernel end
  // word_cnt==WPK, which blocks any accept, so clearing the buffer there
  // cannot drop fresh data.
  always_comb begin
    bbuf_n = bbuf_q;
    base   = bcnt_q;
    if (row_load) begin
      for (int i = 0; i < 5; i++) bbuf_n[i] = bbuf_q[i+3];
      for (int i = 5; i < 8; i++) bbuf_n[i] = 8'h00;
      base = bcnt_q - 4'd3;
    end
    if (word_acc) begin
      for (int j = 0; j < 4; j++) bbuf_n[base[2:0] + 3'(j)] = bus.in_data[8*j +: 8];
    end
    bcnt_n = base + (word_acc ? 4'd4 : 4'd0);
    if (kern_end || start_go) begin
      for (int i = 0; i < 8; i++) bbuf_n[i] = 8'h00;
      bcnt_n = 4'd0;
    end
  end

  // Buffer, counters and latched kernel count
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bbuf_q[i] <= 8'h00;
      bcnt_q     <= 4'd0;
      word_cnt_q <= 4'd0;
      row_cnt_q  <= 3'd0;
      kern_cnt_q <= 16'd0;
      n_kern_q   <= 16'd0;
    end else begin
      bbuf_q <= bbuf_n;
      bcnt_q <= bcnt_n;
      if (start_go) begin
        n_kern_q   <= n_kern;
        word_cnt_q <= 4'd0;
        row_cnt_q  <= 3'd0;
        kern_cnt_q <= 16'd0;
      end else if (kern_end) begin
        word_cnt_q <= 4'd0;
        row_cnt_q  <= 3'd0;
        kern_cnt_q <= kern_cnt_q + 16'd1;
      end else begin
        if (word_acc) word_cnt_q <= word_cnt_q + 4'd1;
        if (row_load) row_cnt_q  <= row_cnt_q + 3'd1;
      end
    end
  end

  // Row output slot. The data bytes keep their value after a take. The
  // downstream register qualifies them with wreg_enb.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrow0_q      <= 8'h00;
      wrow1_q      <= 8'h00;
      wrow2_q      <= 8'h00;
      wrow_valid_q <= 1'b0;
      wrow_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (row_load) begin
        wrow0_q      <= bbuf_q[0];
        wrow1_q      <= bbuf_q[1];
        wrow2_q      <= bbuf_q[2];
        wrow_valid_q <= 1'b1;
        wrow_last_q  <= kern_end;
      end else if (row_take) begin
        wrow_valid_q <= 1'b0;
      end
      done_q <= start_zero || ((state_q == S_DRAIN) && row_take);
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.wrow_0     = wrow0_q;
  assign bus.wrow_1     = wrow1_q;
  assign bus.wrow_2     = wrow2_q;
  assign bus.wrow_valid = wrow_valid_q;
  assign bus.wrow_last  = wrow_last_q;
  assign bus.wreg_enb   = row_take;
  assign done           = done_q;

endmodule

// File: tb/tb_fs_accel_wfetch.sv
// tb_fs_accel_wfetch
//   Directed bench for fs_accel_wfetch with KROWS=3 (3 words per kernel).
//   Expected rows are hand-written constants, packed as {last, b0, b1, b2}.
//   A negedge monitor pops them from exp_q each time wreg_enb is high.
module tb_fs_accel_wfetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] n_kern;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  fs_accel_wfetch_if bus ();

  fs_accel_wfetch #(.KROWS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_kern    (n_kern),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 500000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [24:0] exp_q[$];
  int enb_cnt;
  int done_cnt;
  int done_cyc;
  int last_take_cyc;
  int start_cyc;
  bit in_ready_seen;
  bit busy_seen;

  logic [31:0] words [6] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                             32'h14131211, 32'h18171615, 32'h1C1B1A19};
  logic [24:0] rows [6]  = '{25'h0_010203, 25'h0_040506, 25'h1_070809,
                             25'h0_111213, 25'h0_141516, 25'h1_171819};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.in_ready) in_ready_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.wreg_enb) begin
      enb_cnt++;
      if (bus.wrow_last) last_take_cyc = cyc;
      if (exp_q.size() == 0)
        check("row_unexpected_count", 32'(exp_q.size()), 32'd1);
      else
        check("row", {7'd0, bus.wrow_last, bus.wrow_0, bus.wrow_1, bus.wrow_2},
              {7'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    enb_cnt       = 0;
    done_cnt      = 0;
    done_cyc      = -100;
    last_take_cyc = -100;
    in_ready_seen = 1'b0;
    busy_seen     = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    @(posedge clk); #1;
    start  = 1'b1;
    n_kern = n;
    start_cyc = cyc;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("in_ready_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int t = 0;
    while (done_cnt == 0 && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done_cnt != 0), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    n_kern          = 16'd0;
    bus.in_data     = 32'd0;
    bus.in_valid    = 1'b0;
    bus.wrow_ready  = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready",   32'(bus.in_ready),   32'd0);
    check("rst_wrow_valid", 32'(bus.wrow_valid), 32'd0);
    check("rst_wrow_last",  32'(bus.wrow_last),  32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_done",       32'(done),           32'd0);
    check("rst_wrow",       {8'd0, bus.wrow_0, bus.wrow_1, bus.wrow_2}, 32'd0);
    check("rst_state",      32'(state_dbg),      32'd0);

    // 1) Single kernel, wrow_ready tied high
    clear_stats();
    bus.wrow_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(rows[i]);
    pulse_start(16'd1);
    check("t1_busy_run", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) send_word(words[i]);
    wait_done(50);
    check("t1_done_after_take", 32'(done_cyc - last_take_cyc), 32'd1);
    repeat (3) @(negedge clk);
    check("t1_enb_cnt",  32'(enb_cnt),      32'd3);
    check("t1_done_cnt", 32'(done_cnt),     32'd1);
    check("t1_busy",     32'(busy),         32'd0);
    check("t1_q_empty",  32'(exp_q.size()), 32'd0);
    check("t1_retained", {8'd0, bus.wrow_0, bus.wrow_1, bus.wrow_2}, 32'h070809);

    // 2) Backpressure: wrow_ready low for 5 cycles after the first row
    clear_stats();
    bus.wrow_ready = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(rows[i]);
    pulse_start(16'd1);
    fork
      begin
        for (int i = 0; i < 3; i++) send_word(words[i]);
      end
      begin
        int t = 0;
        while (!bus.wrow_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        check("t2_first_row_timeout", 32'(t < 20), 32'd1);
        for (int k = 0; k < 5; k++) begin
          check("t2_hold_row",   {7'd0, bus.wrow_last, bus.wrow_0, bus.wrow_1, bus.wrow_2},
                32'h0010203);
          check("t2_hold_valid", 32'(bus.wrow_valid), 32'd1);
          check("t2_in_ready",   32'(bus.in_ready),   32'd0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        bus.wrow_ready = 1'b1;
      end
    join
    wait_done(50);
    repeat (3) @(negedge clk);
    check("t2_enb_cnt",  32'(enb_cnt),      32'd3);
    check("t2_done_cnt", 32'(done_cnt),     32'd1);
    check("t2_q_empty",  32'(exp_q.size()), 32'd0);

    // 3) Two kernels
    clear_stats();
    for (int i = 0; i < 6; i++) exp_q.push_back(rows[i]);
    pulse_start(16'd2);
    for (int i = 0; i < 6; i++) send_word(words[i]);
    wait_done(50);
    check("t3_done_after_take", 32'(done_cyc - last_take_cyc), 32'd1);
    repeat (3) @(negedge clk);
    check("t3_enb_cnt",  32'(enb_cnt),      32'd6);
    check("t3_done_cnt", 32'(done_cnt),     32'd1);
    check("t3_q_empty",  32'(exp_q.size()), 32'd0);

    // 4) n_kern = 0
    clear_stats();
    pulse_start(16'd0);
    repeat (4) @(negedge clk);
    check("t4_done_cnt",   32'(done_cnt),            32'd1);
    check("t4_done_cycle", 32'(done_cyc - start_cyc), 32'd1);
    check("t4_in_ready",   32'(in_ready_seen),       32'd0);
    check("t4_busy",       32'(busy_seen),           32'd0);

    // 5) Reset mid-kernel, then a fresh fetch
    clear_stats();
    exp_q.push_back(rows[0]);
    pulse_start(16'd1);
    send_word(words[0]);
    send_word(words[1]);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_in_ready",   32'(bus.in_ready),   32'd0);
    check("t5_wrow_valid", 32'(bus.wrow_valid), 32'd0);
    check("t5_wrow",       {8'd0, bus.wrow_0, bus.wrow_1, bus.wrow_2}, 32'd0);
    check("t5_busy",       32'(busy),           32'd0);
    repeat (3) @(negedge clk);
    check("t5_no_done",    32'(done_cnt),       32'd0);
    check("t5_q_empty",    32'(exp_q.size()),   32'd0);
    clear_stats();
    for (int i = 0; i < 3; i++) exp_q.push_back(rows[i]);
    pulse_start(16'd1);
    for (int i = 0; i < 3; i++) send_word(words[i]);
    wait_done(50);
    repeat (3) @(negedge clk);
    check("t5b_enb_cnt", 32'(enb_cnt),  32'd3);
    check("t5b_done",    32'(done_cnt), 32'd1);

    // 6) start while busy is ignored
    clear_stats();
    for (int i = 0; i < 3; i++) exp_q.push_back(rows[i]);
    pulse_start(16'd1);
    send_word(words[0]);
    pulse_start(16'd5);
    send_word(words[1]);
    send_word(words[2]);
    wait_done(50);
    repeat (10) @(negedge clk);
    check("t6_enb_cnt",  32'(enb_cnt),      32'd3);
    check("t6_done_cnt", 32'(done_cnt),     32'd1);
    check("t6_busy",     32'(busy),         32'd0);
    check("t6_state",    32'(state_dbg),    32'd0);
    check("t6_q_empty",  32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
